uart_tx: RTL

UART transmitter serialising one PAYLOAD_BITS-wide word per frame onto uart_txd. Frame format: start bit, LSB first, STOP_BITS stop bits. Timing and framing parameters are identical to the receive side, so a paired receiver built with the same parameters decodes every frame. Sits between host/debug logic and the FPGA TX pin. Uses a simple enable/busy handshake and also generates BREAK conditions.

---
 rtl/uart_tx.sv | 85 ++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter sending start bit, PAYLOAD_BITS data bits LSB first, then STOP_BITS stop bits.
// Also generates BREAK (line low for PAYLOAD_BITS+2 bit periods plus a stop period).
module uart_tx #(
  parameter int BIT_RATE     = 115200,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_en,
  input  logic                    uart_tx_break,
  output logic                    uart_tx_busy,
  output logic                    uart_txd
);
  localparam int BIT_P = 1_000_000_000 / BIT_RATE;
  localparam int CLK_P = 1_000_000_000 / CLK_HZ;
  localparam int CPB   = BIT_P / CLK_P;
  localparam int CW    = 1 + $clog2(CPB);
  localparam int BW    = 1 + $clog2(PAYLOAD_BITS + STOP_BITS + 2);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;
  logic [2:0]              r_state, w_state;
  logic [CW-1:0]           r_cyc, w_cyc;
  logic [BW-1:0]           r_bit, w_bit;
  logic [PAYLOAD_BITS-1:0] r_sr, w_sr;
  logic                    r_txd, w_txd;
  logic                    r_busy;
  logic                    w_end;
  assign w_end = r_cyc == CW'(CPB - 1);
  // Next-state logic; the line level is derived from the next state so uart_txd stays registered.
  always_comb begin
    w_state = r_state;
    w_sr    = r_sr;
    w_bit   = r_bit;
    w_cyc   = (r_state == S_IDLE || w_end) ? '0 : r_cyc + CW'(1);
    case (r_state)
      S_IDLE: begin
        if (uart_tx_en) begin
          w_state = S_START;
          w_sr    = uart_tx_data;
        end else if (uart_tx_break) w_state = S_BREAK;
      end
      S_START: w_state = w_end ? S_DATA : r_state;
      S_DATA: if (w_end) begin
        w_sr    = r_sr >> 1;
        w_bit   = (r_bit == BW'(PAYLOAD_BITS - 1)) ? '0 : r_bit + BW'(1);
        w_state = (r_bit == BW'(PAYLOAD_BITS - 1)) ? S_STOP : r_state;
      end
      S_STOP: if (w_end) begin
        w_bit   = (r_bit == BW'(STOP_BITS - 1)) ? '0 : r_bit + BW'(1);
        w_state = (r_bit == BW'(STOP_BITS - 1)) ? S_IDLE : r_state;
      end
      S_BREAK: if (w_end) begin
        w_bit   = (r_bit == BW'(PAYLOAD_BITS + 1)) ? '0 : r_bit + BW'(1);
        w_state = (r_bit == BW'(PAYLOAD_BITS + 1)) ? S_STOP : r_state;
      end
      default: w_state = S_IDLE;
    endcase
    w_txd = (w_state == S_START || w_state == S_BREAK) ? 1'b0 : (w_state == S_DATA) ? w_sr[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_sr    <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cyc   <= w_cyc;
      r_bit   <= w_bit;
      r_sr    <= w_sr;
      r_txd   <= w_txd;
      r_busy  <= w_state != S_IDLE;
    end
  end
  assign uart_txd     = r_txd;
  assign uart_tx_busy = r_busy;
endmodule
